// File: rtl/rx_det_sched.sv
// Receiver-detect sweep scheduler: one lane at a time through a shared detector.
// Optional RXDET_RETRY_EN re-requests a timed-out lane once before flagging it.
module rx_det_sched #(
  parameter int NUM_LANES   = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SETTLE_CYC  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_LANES-1:0]             rx_det_seq_ack,
  input  logic [NUM_LANES-1:0]             rx_det_valid,
  output logic [NUM_LANES-1:0]             rx_det_seq_req,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_LANES-1:0]             det_mask,
  output logic [NUM_LANES-1:0]             timeout_mask,
  output logic [$clog2(NUM_LANES+1)-1:0]   det_cnt
);
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW = $clog2(NUM_LANES + 1);
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0] LANE0 = NUM_LANES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [NUM_LANES-1:0]   req_q, req_d;
  logic [NUM_LANES-1:0]   det_q, det_d;
  logic [NUM_LANES-1:0]   to_q, to_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ack_hit, wait_end;
  logic                   settle_end, kill;

`ifdef RXDET_RETRY_EN
  // used: retry already spent on this lane; pend: retry due next cycle
  logic used_q, used_d;
  logic pend_q, pend_d;
`endif

  assign ack_hit    = rx_det_seq_ack[idx_q];
  assign wait_end   = (wait_q == WW'(TIMEOUT_CYC - 1));
  assign settle_end = (settle_q == SW'(SETTLE_CYC - 1));
  assign kill       = abort && (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      settle_q <= '0;
      req_q    <= '0;
      det_q    <= '0;
      to_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RXDET_RETRY_EN
      used_q   <= 1'b0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      req_q    <= req_d;
      det_q    <= det_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef RXDET_RETRY_EN
      used_q   <= used_d;
      pend_q   <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start && !abort) state_d = S_REQ;
        S_REQ: begin
          if (ack_hit)       state_d = S_SETTLE;
          else if (wait_end) state_d = S_NEXT;
        end
        S_SETTLE: if (settle_end) state_d = S_NEXT;
        S_NEXT: begin
`ifdef RXDET_RETRY_EN
          if (pend_q)              state_d = S_REQ;
          else
`endif
          if (idx_q == LAST)       state_d = S_DONE;
          else                     state_d = S_REQ;
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d    = idx_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    req_d    = req_q;
    det_d    = det_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef RXDET_RETRY_EN
    used_d   = used_q;
    pend_d   = pend_q;
`endif
    if (kill) begin
      idx_d    = '0;
      wait_d   = '0;
      settle_d = '0;
      req_d    = '0;
      det_d    = '0;
      to_d     = '0;
      cnt_d    = '0;
      busy_d   = 1'b0;
`ifdef RXDET_RETRY_EN
      used_d   = 1'b0;
      pend_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            idx_d  = '0;
            wait_d = '0;
            req_d  = LANE0;
            det_d  = '0;
            to_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
`ifdef RXDET_RETRY_EN
            used_d = 1'b0;
            pend_d = 1'b0;
`endif
          end
        end
        S_REQ: begin
          wait_d = wait_q + 1'b1;
          if (ack_hit) begin
            req_d    = '0;
            settle_d = '0;
          end else if (wait_end) begin
            req_d        = '0;
            det_d[idx_q] = 1'b0;
`ifdef RXDET_RETRY_EN
            if (!used_q) begin
              used_d = 1'b1;
              pend_d = 1'b1;
            end else begin
              to_d[idx_q] = 1'b1;
            end
`else
            to_d[idx_q] = 1'b1;
`endif
          end
        end
        S_SETTLE: begin
          settle_d = settle_q + 1'b1;
          if (settle_end) begin
            det_d[idx_q] = rx_det_valid[idx_q];
            cnt_d = cnt_q + CW'(rx_det_valid[idx_q]);
          end
        end
        S_NEXT: begin
`ifdef RXDET_RETRY_EN
          if (pend_q) begin
            pend_d = 1'b0;
            wait_d = '0;
            req_d  = LANE0 << idx_q;
          end else
`endif
          if (idx_q == LAST) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            wait_d = '0;
            req_d  = LANE0 << (idx_q + 1'b1);
`ifdef RXDET_RETRY_EN
            used_d = 1'b0;
`endif
          end
        end
        S_DONE: done_d = 1'b0;
        default: begin
          req_d  = '0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  assign rx_det_seq_req = req_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign det_mask       = det_q;
  assign timeout_mask   = to_q;
  assign det_cnt        = cnt_q;

endmodule

// File: tb/tb_rx_det_sched.sv
// Bench for rx_det_sched: lane responder plus a timeline model built per sweep.
// Honours RXDET_RETRY_EN when the model counts request attempts per lane.
module tb_rx_det_sched;
  localparam int N  = 4;
  localparam int T  = 1024;
  localparam int S  = 16;
  localparam int CW = $clog2(N + 1);
  localparam int NEVER = 5000;
`ifdef RXDET_RETRY_EN
  localparam int NATT = 2;
`else
  localparam int NATT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [N-1:0]  ack, valid, req, det_mask, to_mask;
  logic          busy, done;
  logic [CW-1:0] det_cnt;

  int errors = 0;
  int checks = 0;
  int dly[N];
  int dly2[N];
  int cnt[N];
  int att[N];
  logic [N-1:0] prev_req;
  logic [N-1:0] last_det, last_to;

  always #5 clk = ~clk;

  rx_det_sched #(.NUM_LANES(N), .TIMEOUT_CYC(T), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rx_det_seq_ack(ack), .rx_det_valid(valid),
    .rx_det_seq_req(req), .busy(busy), .done(done),
    .det_mask(det_mask), .timeout_mask(to_mask), .det_cnt(det_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane responder: ack a request a fixed number of cycles after it rises
  task automatic drive_ack(input bit noisy);
    logic [N-1:0] r;
    logic [N-1:0] nz;
    r = '0;
    for (int l = 0; l < N; l++) begin
      if (req[l]) begin
        if (!prev_req[l]) begin
          cnt[l] = 0;
          att[l]++;
        end
        cnt[l]++;
        if (cnt[l] == ((att[l] == 1) ? dly[l] : dly2[l])) r[l] = 1'b1;
      end
    end
    prev_req = req;
    nz = noisy ? (N'($urandom) & N'($urandom)) : '0;
    ack = r | (nz & ~req);
  endtask

  task automatic sweep(input int a_at, input int r_at, input bit noisy,
                       input bit snz);
    logic [N+1:0] eq[$];
    logic [N-1:0] edet, eto, lb;
    int dd;
    bit got;
    eq = {};
    edet = '0;
    eto = '0;
    for (int l = 0; l < N; l++) begin
      lb = '0;
      lb[l] = 1'b1;
      got = 1'b0;
      for (int a = 0; a < NATT && !got; a++) begin
        dd = (a == 0) ? dly[l] : dly2[l];
        if (dd <= T) begin
          repeat (dd) eq.push_back({lb, 2'b10});
          repeat (S + 1) eq.push_back({{N{1'b0}}, 2'b10});
          edet[l] = valid[l];
          got = 1'b1;
        end else begin
          repeat (T) eq.push_back({lb, 2'b10});
          eq.push_back({{N{1'b0}}, 2'b10});
          if (a == NATT - 1) eto[l] = 1'b1;
        end
      end
    end
    eq.push_back({{N{1'b0}}, 2'b01});
    eq.push_back({{N{1'b0}}, 2'b00});
    for (int l = 0; l < N; l++) begin
      cnt[l] = 0;
      att[l] = 0;
    end
    prev_req = '0;
    ack = '0;
    start = 1'b1;
    abort = 1'b0;
    tick();
    start = 1'b0;
    chk("clear_on_start", {det_mask, to_mask, det_cnt}, '0);
    for (int k = 0; k < eq.size(); k++) begin
      chk("trace_req_busy_done", {req, busy, done}, eq[k]);
      if (eq[k][0] || k == eq.size() - 1) begin
        chk("det_mask", det_mask, edet);
        chk("timeout_mask", to_mask, eto);
        chk("det_cnt", det_cnt, $countones(edet));
      end
      if (k == eq.size() - 1) break;
      if (k == a_at || k == r_at) begin
        if (k == a_at) abort = 1'b1;
        else rst = 1'b1;
        ack = '0;
        start = 1'b0;
        tick();
        abort = 1'b0;
        rst = 1'b0;
        chk("kill_outputs", {req, busy, done, det_mask, to_mask, det_cnt}, '0);
        repeat (3) begin
          tick();
          chk("kill_idle", {req, busy, done, det_cnt}, '0);
        end
        edet = '0;
        eto = '0;
        break;
      end
      drive_ack(noisy);
      start = (snz && k < eq.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
    ack = '0;
    last_det = edet;
    last_to = eto;
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    dly[3] = d3;
    for (int l = 0; l < N; l++) dly2[l] = NEVER;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ack = '0;
    valid = '0;
    prev_req = '0;
    repeat (2) tick();
    chk("reset_outputs", {req, busy, done, det_mask, to_mask, det_cnt}, '0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", {req, busy, done, det_cnt}, '0);

    // nominal sweep
    set_dly(3, 3, 3, 3);
    valid = 4'b1011;
    sweep(-1, -1, 1'b0, 1'b0);

    // lane 2 silent for every attempt
    set_dly(3, 3, NEVER, 3);
    valid = 4'b1111;
    sweep(-1, -1, 1'b0, 1'b0);

    // lane 1 silent first, acks 5 cycles into the retry
    set_dly(3, NEVER, 3, 3);
    dly2[1] = 5;
    valid = 4'b0010;
    sweep(-1, -1, 1'b0, 1'b0);

    // ack on the timeout-expiry cycle counts as acked
    set_dly(1, T, 2, 4);
    valid = 4'b0110;
    sweep(-1, -1, 1'b1, 1'b0);

    // abort in lane 1 settle, then a fresh sweep from lane 0
    set_dly(3, 3, 3, 3);
    valid = 4'b1111;
    sweep(25, -1, 1'b0, 1'b0);
    valid = 4'b0101;
    sweep(-1, -1, 1'b0, 1'b0);

    // abort and start together in idle: no sweep, results hold
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", {req, busy, done}, '0);
    chk("abort_start_det_hold", det_mask, last_det);
    tick();
    chk("abort_start_still_idle", {req, busy, done}, '0);

    // start pulses while busy are ignored
    set_dly(2, 1, 4, 3);
    valid = 4'b1100;
    sweep(-1, -1, 1'b1, 1'b1);

    // randomized sweeps
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < N; l++) begin
        dly[l] = ($urandom_range(0, 15) == 0) ?
                 (T - 1 + $urandom_range(0, 2)) : $urandom_range(1, 8);
        dly2[l] = $urandom_range(1, 6);
      end
      valid = N'($urandom);
      sweep(-1, -1, 1'b1, 1'b1);
    end

    // reset while lane 2 is requesting
    set_dly(3, 3, NEVER, 3);
    valid = 4'b1111;
    sweep(-1, 45, 1'b0, 1'b0);
    set_dly(3, 3, 3, 3);
    valid = 4'b1001;
    sweep(-1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
